// File: rtl/jtag_scan_checker_if.sv
// Bus between the bench sequencer and the boundary-scan pattern engine:
// pattern/control inputs, the serial scan pair and the run results.
interface jtag_scan_checker_if #(
  parameter int SCAN_LEN = 253,
  parameter int LW       = 9
);
  logic                load;
  logic                start;
  logic [LW-1:0]       length;
  logic [SCAN_LEN-1:0] tdi_pattern;
  logic [SCAN_LEN-1:0] exp_pattern;
  logic [SCAN_LEN-1:0] cmp_mask;
  logic                from_TDO;
  logic                to_TDI;
  logic                shift_en;
  logic                busy;
  logic                done;
  logic                pass;
  logic [LW-1:0]       err_count;
  logic [LW-1:0]       first_fail;
  logic [SCAN_LEN-1:0] captured;

  modport master (
    output load, start, length, tdi_pattern, exp_pattern, cmp_mask, from_TDO,
    input  to_TDI, shift_en, busy, done, pass, err_count, first_fail, captured
  );

  modport slave (
    input  load, start, length, tdi_pattern, exp_pattern, cmp_mask, from_TDO,
    output to_TDI, shift_en, busy, done, pass, err_count, first_fail, captured
  );
endinterface

// File: rtl/jtag_scan_checker.sv
// Boundary-scan pattern engine: shifts a stimulus out LSB-first on TDI, captures
// TDO after a fixed pipeline latency and checks it against a masked expectation.
module jtag_scan_checker #(
  parameter int SCAN_LEN = 253,
  parameter int TDO_LAT  = 0,
  parameter int LW       = 9
) (
  input  logic              TCK,
  input  logic              reset,
  jtag_scan_checker_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int            IW       = (SCAN_LEN > 1) ? $clog2(SCAN_LEN) : 1;
  localparam logic [2:0]    LAT      = 3'(TDO_LAT);
  localparam logic [LW-1:0] FULL_LEN = LW'(SCAN_LEN);
  localparam logic [LW-1:0] ONE      = LW'(1);

  state_t              state_q, state_d;
  logic [SCAN_LEN-1:0] tdi_q, tdi_d;
  logic [SCAN_LEN-1:0] exp_q, exp_d;
  logic [SCAN_LEN-1:0] mask_q, mask_d;
  logic [SCAN_LEN-1:0] sh_q, sh_d;
  logic [SCAN_LEN-1:0] cap_q, cap_d;
  logic [LW-1:0]       len_q, len_d;
  logic [LW-1:0]       scnt_q, scnt_d;
  logic [LW-1:0]       k_q, k_d;
  logic [LW-1:0]       err_q, err_d;
  logic [LW-1:0]       ff_q, ff_d;
  logic [2:0]          lat_q, lat_d;
  logic                to_tdi_q, to_tdi_d;
  logic                shift_en_q, shift_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [LW-1:0]       eff_len_s;
  logic [IW-1:0]       idx_s;
  logic                cap_fire_s;

  // Next-state, capture/compare and registered-output decode.
  always_comb begin
    state_d    = state_q;
    tdi_d      = tdi_q;
    exp_d      = exp_q;
    mask_d     = mask_q;
    sh_d       = sh_q;
    cap_d      = cap_q;
    len_d      = len_q;
    scnt_d     = scnt_q;
    k_d        = k_q;
    err_d      = err_q;
    ff_d       = ff_q;
    lat_d      = lat_q;
    to_tdi_d   = to_tdi_q;
    pass_d     = pass_q;
    cap_fire_s = 1'b0;
    idx_s      = k_q[IW-1:0];

    if (bus.length == {LW{1'b0}} || bus.length > FULL_LEN) begin
      eff_len_s = FULL_LEN;
    end else begin
      eff_len_s = bus.length;
    end

    // Capture runs through SHIFT and DRAIN once the latency has elapsed;
    // k is the index of the stimulus bit whose image is on from_TDO now.
    if (state_q == SHIFT || state_q == DRAIN) begin
      if (lat_q != 3'd0) begin
        lat_d = lat_q - 3'd1;
      end else begin
        cap_fire_s   = 1'b1;
        cap_d[idx_s] = bus.from_TDO;
        k_d          = k_q + ONE;
        if (mask_q[idx_s] && (bus.from_TDO != exp_q[idx_s])) begin
          err_d = err_q + ONE;
          if (err_q == {LW{1'b0}}) begin
            ff_d = k_q;
          end else begin
            ff_d = ff_q;
          end
        end else begin
          err_d = err_q;
        end
      end
    end else begin
      lat_d = lat_q;
    end

    case (state_q)
      IDLE: begin
        if (bus.load) begin
          tdi_d  = bus.tdi_pattern;
          exp_d  = bus.exp_pattern;
          mask_d = bus.cmp_mask;
        end else if (bus.start) begin
          len_d    = eff_len_s;
          scnt_d   = {LW{1'b0}};
          k_d      = {LW{1'b0}};
          lat_d    = LAT;
          to_tdi_d = tdi_q[0];
          sh_d     = tdi_q >> 1'b1;
          cap_d    = {SCAN_LEN{1'b0}};
          err_d    = {LW{1'b0}};
          ff_d     = {LW{1'b0}};
          pass_d   = 1'b0;
          state_d  = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (scnt_q == len_q - ONE) begin
          to_tdi_d = 1'b0;
          if (LAT == 3'd0) begin
            state_d = DONE;
          end else begin
            state_d = DRAIN;
          end
        end else begin
          to_tdi_d = sh_q[0];
          sh_d     = sh_q >> 1'b1;
          scnt_d   = scnt_q + ONE;
        end
      end
      DRAIN: begin
        to_tdi_d = 1'b0;
        if (cap_fire_s && (k_q == len_q - ONE)) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d     = (state_d != IDLE);
    shift_en_d = (state_d == SHIFT);
    done_d     = (state_d == DONE);
    // Verdict includes the final bit compared in the cycle that enters DONE.
    if (state_d == DONE && state_q != DONE) begin
      pass_d = (err_d == {LW{1'b0}});
    end else begin
      pass_d = pass_d;
    end
  end

  // State, pattern and result registers.
  always_ff @(posedge TCK or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      tdi_q      <= {SCAN_LEN{1'b0}};
      exp_q      <= {SCAN_LEN{1'b0}};
      mask_q     <= {SCAN_LEN{1'b0}};
      sh_q       <= {SCAN_LEN{1'b0}};
      cap_q      <= {SCAN_LEN{1'b0}};
      len_q      <= {LW{1'b0}};
      scnt_q     <= {LW{1'b0}};
      k_q        <= {LW{1'b0}};
      err_q      <= {LW{1'b0}};
      ff_q       <= {LW{1'b0}};
      lat_q      <= 3'd0;
      to_tdi_q   <= 1'b0;
      shift_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tdi_q      <= tdi_d;
      exp_q      <= exp_d;
      mask_q     <= mask_d;
      sh_q       <= sh_d;
      cap_q      <= cap_d;
      len_q      <= len_d;
      scnt_q     <= scnt_d;
      k_q        <= k_d;
      err_q      <= err_d;
      ff_q       <= ff_d;
      lat_q      <= lat_d;
      to_tdi_q   <= to_tdi_d;
      shift_en_q <= shift_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  assign bus.to_TDI     = to_tdi_q;
  assign bus.shift_en   = shift_en_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.first_fail = ff_q;
  assign bus.captured   = cap_q;

endmodule

// File: tb/tb_jtag_scan_checker.sv
// Directed bench: one engine with TDO_LAT=0 on a switchable loopback and one with
// TDO_LAT=2 behind a two-stage delay line.
module tb_jtag_scan_checker;

  logic TCK = 1'b0;
  logic rst;
  logic lb0;
  logic d1, d2;
  int   n_cmp = 0;
  int   n_mis = 0;
  int   sh, bz, dj;

  jtag_scan_checker_if #(.SCAN_LEN(8), .LW(4)) if0 ();
  jtag_scan_checker_if #(.SCAN_LEN(8), .LW(4)) if2 ();

  jtag_scan_checker #(.SCAN_LEN(8), .TDO_LAT(0), .LW(4)) u_dut0 (
    .TCK(TCK), .reset(rst), .bus(if0)
  );
  jtag_scan_checker #(.SCAN_LEN(8), .TDO_LAT(2), .LW(4)) u_dut2 (
    .TCK(TCK), .reset(rst), .bus(if2)
  );

  always #5 TCK = ~TCK;

  assign if0.from_TDO = lb0 ? if0.to_TDI : 1'b0;

  always @(posedge TCK) begin
    d1 <= if2.to_TDI;
    d2 <= d1;
  end
  assign if2.from_TDO = d2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_pat(input bit sel, input logic [7:0] tdi, input logic [7:0] ex,
                          input logic [7:0] mk);
    if (sel) begin
      if2.tdi_pattern = tdi; if2.exp_pattern = ex; if2.cmp_mask = mk; if2.load = 1'b1;
    end else begin
      if0.tdi_pattern = tdi; if0.exp_pattern = ex; if0.cmp_mask = mk; if0.load = 1'b1;
    end
    @(negedge TCK);
    if2.load = 1'b0;
    if0.load = 1'b0;
  endtask

  // Starts a run and watches it; sj/lj inject start/load at run cycle j (0 = never).
  task automatic run(input bit sel, input logic [3:0] len, input int sj, input int lj,
                     output int nsh, output int nbz, output int ndj);
    nsh = 0; nbz = 0; ndj = 0;
    if (sel) begin if2.length = len; if2.start = 1'b1; end
    else     begin if0.length = len; if0.start = 1'b1; end
    @(negedge TCK);
    for (int j = 1; j <= 40; j++) begin
      if (sel) begin
        nsh += int'(if2.shift_en); nbz += int'(if2.busy);
        if (if2.done) ndj = j;
        if2.start = (j == sj); if2.load = (j == lj);
      end else begin
        nsh += int'(if0.shift_en); nbz += int'(if0.busy);
        if (if0.done) ndj = j;
        if0.start = (j == sj); if0.load = (j == lj);
      end
      if (ndj != 0) break;
      @(negedge TCK);
    end
    if2.start = 1'b0; if2.load = 1'b0;
    if0.start = 1'b0; if0.load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; lb0 = 1'b1;
    if0.load = 1'b0; if0.start = 1'b0; if0.length = 4'd0;
    if0.tdi_pattern = 8'h00; if0.exp_pattern = 8'h00; if0.cmp_mask = 8'h00;
    if2.load = 1'b0; if2.start = 1'b0; if2.length = 4'd0;
    if2.tdi_pattern = 8'h00; if2.exp_pattern = 8'h00; if2.cmp_mask = 8'h00;
    repeat (2) @(negedge TCK);
    chk("reset_out0", {if0.to_TDI, if0.shift_en, if0.busy, if0.done, if0.pass,
                       if0.err_count, if0.first_fail, if0.captured}, 32'd0);
    chk("reset_out2", {if2.to_TDI, if2.shift_en, if2.busy, if2.done, if2.pass,
                       if2.err_count, if2.first_fail, if2.captured}, 32'd0);
    rst = 1'b0;
    @(negedge TCK);

    // Loopback, full length via length=0.
    load_pat(1'b0, 8'hA5, 8'hA5, 8'hFF);
    run(1'b0, 4'd0, 0, 0, sh, bz, dj);
    chk("t1_shift_cycles", sh, 32'd8);
    chk("t1_busy_cycles", bz, 32'd9);
    chk("t1_done_cycle", dj, 32'd9);
    chk("t1_pass", if0.pass, 32'd1);
    chk("t1_err_count", if0.err_count, 32'd0);
    chk("t1_captured", if0.captured, 32'hA5);
    @(negedge TCK);
    chk("t1_after_done_busy_done", {if0.busy, if0.done}, 32'd0);

    // Single mismatch on bit 0.
    load_pat(1'b0, 8'hA5, 8'hA4, 8'hFF);
    run(1'b0, 4'd8, 0, 0, sh, bz, dj);
    chk("t2_done_cycle", dj, 32'd9);
    chk("t2_pass", if0.pass, 32'd0);
    chk("t2_err_count", if0.err_count, 32'd1);
    chk("t2_first_fail", if0.first_fail, 32'd0);
    repeat (2) @(negedge TCK);
    chk("t2_results_stable", {if0.pass, if0.err_count, if0.captured}, {1'b0, 4'd1, 8'hA5});

    // Bit 0 masked off; length beyond SCAN_LEN clamps to 8.
    load_pat(1'b0, 8'hA5, 8'hA4, 8'hFE);
    run(1'b0, 4'd15, 0, 0, sh, bz, dj);
    chk("t3_shift_cycles_clamped", sh, 32'd8);
    chk("t3_pass", if0.pass, 32'd1);
    chk("t3_err_count", if0.err_count, 32'd0);

    // Latency 2, partial length 5.
    load_pat(1'b1, 8'h3C, 8'h3C, 8'hFF);
    run(1'b1, 4'd5, 0, 0, sh, bz, dj);
    chk("t4_shift_cycles", sh, 32'd5);
    chk("t4_busy_cycles", bz, 32'd8);
    chk("t4_done_cycle", dj, 32'd8);
    chk("t4_captured", if2.captured, 32'h1C);
    chk("t4_pass", if2.pass, 32'd1);

    // TDO stuck at 0 against exp=FF on the upper nibble.
    lb0 = 1'b0;
    load_pat(1'b0, 8'hA5, 8'hFF, 8'hF0);
    run(1'b0, 4'd8, 0, 0, sh, bz, dj);
    chk("t5_err_count", if0.err_count, 32'd4);
    chk("t5_first_fail", if0.first_fail, 32'd4);
    chk("t5_captured", if0.captured, 32'h00);
    chk("t5_pass", if0.pass, 32'd0);
    lb0 = 1'b1;

    // start during SHIFT and load during DRAIN must be ignored.
    if2.tdi_pattern = 8'hFF; if2.exp_pattern = 8'h00; if2.cmp_mask = 8'hFF;
    run(1'b1, 4'd5, 2, 6, sh, bz, dj);
    chk("t6_done_cycle", dj, 32'd8);
    chk("t6_captured", if2.captured, 32'h1C);
    chk("t6_pass", if2.pass, 32'd1);
    @(negedge TCK);
    run(1'b1, 4'd5, 0, 0, sh, bz, dj);
    chk("t6_replay_captured", if2.captured, 32'h1C);
    chk("t6_replay_pass", if2.pass, 32'd1);

    // load and start together in IDLE: load wins, no run.
    if0.tdi_pattern = 8'h0F; if0.exp_pattern = 8'h0F; if0.cmp_mask = 8'hFF;
    if0.length = 4'd8; if0.load = 1'b1; if0.start = 1'b1;
    @(negedge TCK);
    if0.load = 1'b0; if0.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t7_no_run_busy", if0.busy, 32'd0);
      @(negedge TCK);
    end
    run(1'b0, 4'd8, 0, 0, sh, bz, dj);
    chk("t7_new_pattern_captured", if0.captured, 32'h0F);
    chk("t7_new_pattern_pass", if0.pass, 32'd1);

    // Reset in the middle of SHIFT.
    @(negedge TCK);
    if0.length = 4'd0; if0.start = 1'b1;
    @(negedge TCK);
    if0.start = 1'b0;
    repeat (2) @(negedge TCK);
    chk("t8_in_shift", if0.shift_en, 32'd1);
    rst = 1'b1;
    #1;
    chk("t8_reset_immediate", {if0.to_TDI, if0.shift_en, if0.busy, if0.done, if0.pass,
                               if0.err_count, if0.first_fail, if0.captured}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge TCK);
      chk("t8_no_done", {if0.busy, if0.done}, 32'd0);
    end
    rst = 1'b0;
    @(negedge TCK);
    load_pat(1'b0, 8'hA5, 8'hA5, 8'hFF);
    run(1'b0, 4'd0, 0, 0, sh, bz, dj);
    chk("t8_replay_shift_cycles", sh, 32'd8);
    chk("t8_replay_done_cycle", dj, 32'd9);
    chk("t8_replay_captured", if0.captured, 32'hA5);
    chk("t8_replay_pass", if0.pass, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
